// File: rtl/switch_pkg.sv
// Shared definitions for the switch conditioning front-end: channel FSM encoding,
// edge-mode selectors and default debounce lengths for simulation and board builds.
package switch_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONFIRM = 1'b1
    } ch_state_t;

    localparam int EDGE_BOTH = 0;
    localparam int EDGE_RISE = 1;

    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 500000;

    // Smallest counter width that can hold the given debounce length.
    function automatic int min_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int CNT_W_SIM   = 16;
    localparam int CNT_W_BOARD = min_cnt_w(DEBOUNCE_BOARD);

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, counter debouncer and registered edge pulse.
// Level accepted DEBOUNCE_CYCLES+2 edges after the raw sample; no backpressure (free-running).
module sw_debounce_ch
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int EDGE_MODE       = EDGE_BOTH,
    parameter int CNT_W           = CNT_W_SIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    ch_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // cnt counts confirming cycles; it is cleared on every exit so it never exceeds LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (sync2 != level) begin
                        state <= ST_CONFIRM;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (sync2 == level) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LIMIT) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        level <= sync2;
                        pulse <= (EDGE_MODE == EDGE_BOTH) || sync2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_pulse_gen.sv
// Conditions three raw switches into clean one-cycle event pulses S1..S3 plus debounced levels.
// Pulse high for the cycle after the accepting edge (DEBOUNCE_CYCLES+2 edges after sampling); no backpressure.
module switch_pulse_gen
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int EDGE_MODE       = EDGE_BOTH,
    parameter int CNT_W           = CNT_W_SIM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_raw,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic [2:0] sw_state
);

    logic [2:0] ch_pulse;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_MODE       (EDGE_MODE),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_raw[i]),
            .level (sw_state[i]),
            .pulse (ch_pulse[i])
        );
    end

    assign S1 = ch_pulse[0];
    assign S2 = ch_pulse[1];
    assign S3 = ch_pulse[2];

endmodule

// File: tb/tb_switch_pulse_gen.sv
// Directed bench for switch_pulse_gen: a both-edge and a rise-only instance share the same stimulus.
module tb_switch_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw_raw = 3'b000;

    logic       s1a, s2a, s3a, s1b, s2b, s3b;
    logic [2:0] st_a, st_b;
    logic [2:0] pa, pb;

    assign pa = {s3a, s2a, s1a};
    assign pb = {s3b, s2b, s1b};

    switch_pulse_gen #(.DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .CNT_W(16)) u_both (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
        .S1(s1a), .S2(s2a), .S3(s3a), .sw_state(st_a)
    );

    switch_pulse_gen #(.DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .CNT_W(16)) u_rise (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
        .S1(s1b), .S2(s2b), .S3(s3b), .sw_state(st_b)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [2:0] raw;
        int         hold;
        logic [2:0] exp_state;
        logic [2:0] exp_p0;
        logic [2:0] exp_p1;
        int         exp_lat;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   pc0 [3];
    int   pc1 [3];
    int   first0;
    int   edge_idx;
    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            pc0[i] = 0;
            pc1[i] = 0;
        end
        first0   = -1;
        edge_idx = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pa[i]) pc0[i]++;
            if (pb[i]) pc1[i]++;
        end
        if (pa != 3'b000 && first0 < 0) first0 = edge_idx;
        edge_idx++;
    endtask

    task automatic apply(input logic [2:0] raw, input int n);
        sw_raw = raw;
        clear_counts();
        repeat (n) step();
    endtask

    initial begin
        vecs[0]  = '{3'b001, 30, 3'b001, 3'b001, 3'b001, 6};
        vecs[1]  = '{3'b000, 30, 3'b000, 3'b001, 3'b000, 6};
        vecs[2]  = '{3'b110, 30, 3'b110, 3'b110, 3'b110, 6};
        vecs[3]  = '{3'b000, 30, 3'b000, 3'b110, 3'b000, 6};
        vecs[4]  = '{3'b100,  3, 3'b000, 3'b000, 3'b000, -1};
        vecs[5]  = '{3'b000, 20, 3'b000, 3'b000, 3'b000, -1};
        vecs[6]  = '{3'b010,  4, 3'b000, 3'b000, 3'b000, -1};
        vecs[7]  = '{3'b000, 20, 3'b000, 3'b000, 3'b000, -1};
        vecs[8]  = '{3'b010,  5, 3'b000, 3'b000, 3'b000, -1};
        vecs[9]  = '{3'b000,  2, 3'b010, 3'b010, 3'b010, 1};
        vecs[10] = '{3'b000, 30, 3'b000, 3'b010, 3'b000, 4};
        vecs[11] = '{3'b111, 30, 3'b111, 3'b111, 3'b111, 6};
        vecs[12] = '{3'b000, 30, 3'b000, 3'b111, 3'b000, 6};

        // Reset with all switches held high, then release: a fresh press on every channel.
        rst_n  = 1'b0;
        sw_raw = 3'b111;
        clear_counts();
        repeat (3) step();
        chk("rst_state_a", 32'(st_a), 32'd0);
        chk("rst_pulse_a", 32'(pa), 32'd0);
        chk("rst_state_b", 32'(st_b), 32'd0);
        chk("rst_pulse_b", 32'(pb), 32'd0);
        rst_n = 1'b1;
        clear_counts();
        for (int e = 0; e < 8; e++) begin
            step();
            if (e == 5) begin
                chk("rel_e5_state", 32'(st_a), 32'd0);
                chk("rel_e5_pulse", 32'(pa), 32'd0);
            end
            if (e == 6) begin
                chk("rel_e6_state", 32'(st_a), 32'd7);
                chk("rel_e6_pulse_a", 32'(pa), 32'd7);
                chk("rel_e6_pulse_b", 32'(pb), 32'd7);
            end
            if (e == 7) chk("rel_e7_pulse", 32'(pa), 32'd0);
        end
        apply(3'b000, 30);
        chk("rel_off_state", 32'(st_a), 32'd0);

        for (int k = 0; k < 13; k++) begin
            apply(vecs[k].raw, vecs[k].hold);
            chk($sformatf("v%0d_state", k), 32'(st_a), 32'(vecs[k].exp_state));
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("v%0d_both_ch%0d_pulses", k, i), 32'(pc0[i]), 32'(vecs[k].exp_p0[i]));
                chk($sformatf("v%0d_rise_ch%0d_pulses", k, i), 32'(pc1[i]), 32'(vecs[k].exp_p1[i]));
            end
            if (vecs[k].exp_lat >= 0)
                chk($sformatf("v%0d_latency", k), 32'(first0), 32'(vecs[k].exp_lat));
        end

        // Bounce on switch 1: 2-cycle toggles are filtered, the final settle yields one pulse.
        clear_counts();
        for (int b = 0; b < 4; b++) begin
            sw_raw = (b % 2 == 0) ? 3'b010 : 3'b000;
            repeat (2) step();
        end
        chk("bounce_quiet", 32'(pc0[0] + pc0[1] + pc0[2]), 32'd0);
        apply(3'b010, 30);
        chk("bounce_s2_count", 32'(pc0[1]), 32'd1);
        chk("bounce_other", 32'(pc0[0] + pc0[2]), 32'd0);
        chk("bounce_latency", 32'(first0), 32'd6);
        chk("bounce_state", 32'(st_a), 32'd2);
        apply(3'b000, 30);
        chk("bounce_off_state", 32'(st_a), 32'd0);

        // Reset while channel 1 is confirming (cnt=2): count abandoned, no pulse afterwards.
        apply(3'b001, 30);
        chk("mid_pre_state", 32'(st_a), 32'd1);
        apply(3'b011, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_state_a", 32'(st_a), 32'd0);
        chk("mid_async_state_b", 32'(st_b), 32'd0);
        chk("mid_async_pulse", 32'(pa), 32'd0);
        sw_raw = 3'b000;
        repeat (2) step();
        rst_n = 1'b1;
        apply(3'b000, 30);
        chk("mid_s2_pulses", 32'(pc0[1]), 32'd0);
        chk("mid_all_pulses", 32'(pc0[0] + pc0[2] + pc1[0] + pc1[1] + pc1[2]), 32'd0);
        chk("mid_state", 32'(st_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
